mef_sensor_scheduler: RTL and testbench

MEF_SENSOR_SCHEDULER -- requirements
Module: mef_sensor_scheduler

---
 rtl/mef_sensor_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_mef_sensor_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mef_sensor_scheduler.sv
// mef_sensor_scheduler: accepts command packets into a one-deep pending slot,
// runs single or continuous (loop) sensor reads, and hands a response record
// to the transmitter. Pending commands always preempt loop service.
module mef_sensor_scheduler #(
    parameter int NUM_ADDR       = 32,
    parameter int DATA_W         = 40,
    parameter int TIMEOUT_CYCLES = 130000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                new_data,
    input  logic [7:0]          next_command,
    input  logic [7:0]          next_address,
    input  logic                sensor_done,
    input  logic                sensor_error,
    input  logic [DATA_W-1:0]   data_sensor,
    input  logic                tx_busy,
    output logic                sensor_start,
    output logic [7:0]          sensor_addr,
    output logic                send_data_tx,
    output logic [2:0]          resp_status,
    output logic [7:0]          resp_command,
    output logic [7:0]          resp_address,
    output logic [DATA_W-1:0]   resp_data,
    output logic                rest_uart_rx,
    output logic [NUM_ADDR-1:0] loop_active,
    output logic [NUM_ADDR-1:0] loop_kind,
    output logic                cmd_dropped
);

    localparam int AW    = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [8:0]       ADDR_LIMIT  = 9'(NUM_ADDR);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_DECODE      = 3'd1;
    localparam logic [2:0] ST_SENSOR_REQ  = 3'd2;
    localparam logic [2:0] ST_SENSOR_WAIT = 3'd3;
    localparam logic [2:0] ST_RESPOND     = 3'd4;

    localparam logic [2:0] RS_OK        = 3'd0;
    localparam logic [2:0] RS_BAD_CMD   = 3'd1;
    localparam logic [2:0] RS_BAD_ADDR  = 3'd2;
    localparam logic [2:0] RS_SENS_ERR  = 3'd3;
    localparam logic [2:0] RS_TIMEOUT   = 3'd4;
    localparam logic [2:0] RS_STOPPED   = 3'd5;
    localparam logic [2:0] RS_NO_LOOP   = 3'd6;

    logic [2:0]        state;
    logic              slot_full;
    logic [7:0]        slot_cmd;
    logic [7:0]        slot_addr;
    logic              slot_take;

    logic [7:0]        cur_cmd;
    logic [7:0]        cur_addr;
    logic [2:0]        cur_status;
    logic [DATA_W-1:0] cur_data;
    logic [CNT_W-1:0]  timeout_cnt;
    logic [AW-1:0]     rr_ptr;

    logic              rr_found;
    logic [AW-1:0]     rr_next;

    logic [AW-1:0]     dec_idx;
    logic              dec_bad_cmd;
    logic              dec_bad_addr;
    logic              dec_kind_match;

    // The slot is drained on the same edge the FSM copies it into DECODE.
    assign slot_take = (state == ST_IDLE) && slot_full;

    assign dec_idx        = cur_addr[AW-1:0];
    assign dec_bad_cmd    = (cur_cmd == 8'd0) || (cur_cmd > 8'd7);
    assign dec_bad_addr   = ({1'b0, cur_addr} >= ADDR_LIMIT);
    assign dec_kind_match = loop_active[dec_idx] &&
                            (loop_kind[dec_idx] == (cur_cmd == 8'd7));

    assign sensor_start = (state == ST_SENSOR_REQ);
    assign sensor_addr  = cur_addr;

    // Round-robin search: first active loop address strictly after the last one serviced.
    always_comb begin : rr_search
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_next  = '0;
        for (int k = 1; k <= NUM_ADDR; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_ADDR;
            if (!rr_found && loop_active[AW'(idx)]) begin
                rr_found = 1'b1;
                rr_next  = AW'(idx);
            end
        end
    end

    // Pending slot capture; a packet arriving while the slot is occupied is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_full    <= 1'b0;
            slot_cmd     <= '0;
            slot_addr    <= '0;
            rest_uart_rx <= 1'b0;
            cmd_dropped  <= 1'b0;
        end else begin
            rest_uart_rx <= 1'b0;
            cmd_dropped  <= 1'b0;
            if (slot_take) begin
                slot_full <= 1'b0;
            end
            if (new_data) begin
                if (slot_full) begin
                    cmd_dropped <= 1'b1;
                end else begin
                    slot_full    <= 1'b1;
                    slot_cmd     <= next_command;
                    slot_addr    <= next_address;
                    rest_uart_rx <= 1'b1;
                end
            end
        end
    end

    // Main sequencer: decode, sensor handshake with timeout, loop bookkeeping and response hand-off.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_cmd      <= '0;
            cur_addr     <= '0;
            cur_status   <= '0;
            cur_data     <= '0;
            timeout_cnt  <= '0;
            rr_ptr       <= '0;
            loop_active  <= '0;
            loop_kind    <= '0;
            send_data_tx <= 1'b0;
            resp_status  <= '0;
            resp_command <= '0;
            resp_address <= '0;
            resp_data    <= '0;
        end else begin
            send_data_tx <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (slot_full) begin
                        cur_cmd  <= slot_cmd;
                        cur_addr <= slot_addr;
                        state    <= ST_DECODE;
                    end else if (rr_found) begin
                        cur_cmd  <= loop_kind[rr_next] ? 8'd5 : 8'd4;
                        cur_addr <= 8'(rr_next);
                        rr_ptr   <= rr_next;
                        state    <= ST_SENSOR_REQ;
                    end
                end
                ST_DECODE: begin
                    if (dec_bad_cmd) begin
                        cur_status <= RS_BAD_CMD;
                        state      <= ST_RESPOND;
                    end else if (dec_bad_addr) begin
                        cur_status <= RS_BAD_ADDR;
                        state      <= ST_RESPOND;
                    end else if (cur_cmd < 8'd4) begin
                        state <= ST_SENSOR_REQ;
                    end else if (cur_cmd < 8'd6) begin
                        loop_active[dec_idx] <= 1'b1;
                        loop_kind[dec_idx]   <= (cur_cmd == 8'd5);
                        state                <= ST_SENSOR_REQ;
                    end else begin
                        if (dec_kind_match) begin
                            loop_active[dec_idx] <= 1'b0;
                            cur_status           <= RS_STOPPED;
                        end else begin
                            cur_status <= RS_NO_LOOP;
                        end
                        state <= ST_RESPOND;
                    end
                end
                ST_SENSOR_REQ: begin
                    timeout_cnt <= '0;
                    state       <= ST_SENSOR_WAIT;
                end
                ST_SENSOR_WAIT: begin
                    if (sensor_error) begin
                        cur_status <= RS_SENS_ERR;
                        state      <= ST_RESPOND;
                    end else if (sensor_done) begin
                        cur_data   <= data_sensor;
                        cur_status <= RS_OK;
                        state      <= ST_RESPOND;
                    end else if (timeout_cnt == TIMEOUT_VAL) begin
                        cur_status <= RS_TIMEOUT;
                        state      <= ST_RESPOND;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (!tx_busy) begin
                        send_data_tx <= 1'b1;
                        resp_status  <= cur_status;
                        resp_command <= cur_cmd;
                        resp_address <= cur_addr;
                        resp_data    <= (cur_status == RS_OK) ? cur_data : '0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mef_sensor_scheduler.sv
// tb_mef_sensor_scheduler: directed scenarios for the sensor scheduler with
// hand-computed expected responses, run against a short timeout.
module tb_mef_sensor_scheduler;

    localparam int NUM_ADDR       = 32;
    localparam int DATA_W         = 40;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clock = 1'b0;
    logic                reset;
    logic                new_data;
    logic [7:0]          next_command;
    logic [7:0]          next_address;
    logic                sensor_done;
    logic                sensor_error;
    logic [DATA_W-1:0]   data_sensor;
    logic                tx_busy;
    logic                sensor_start;
    logic [7:0]          sensor_addr;
    logic                send_data_tx;
    logic [2:0]          resp_status;
    logic [7:0]          resp_command;
    logic [7:0]          resp_address;
    logic [DATA_W-1:0]   resp_data;
    logic                rest_uart_rx;
    logic [NUM_ADDR-1:0] loop_active;
    logic [NUM_ADDR-1:0] loop_kind;
    logic                cmd_dropped;

    int total = 0;
    int bad = 0;
    int tx_count = 0;
    int start_count = 0;

    mef_sensor_scheduler #(
        .NUM_ADDR(NUM_ADDR),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .new_data(new_data),
        .next_command(next_command),
        .next_address(next_address),
        .sensor_done(sensor_done),
        .sensor_error(sensor_error),
        .data_sensor(data_sensor),
        .tx_busy(tx_busy),
        .sensor_start(sensor_start),
        .sensor_addr(sensor_addr),
        .send_data_tx(send_data_tx),
        .resp_status(resp_status),
        .resp_command(resp_command),
        .resp_address(resp_address),
        .resp_data(resp_data),
        .rest_uart_rx(rest_uart_rx),
        .loop_active(loop_active),
        .loop_kind(loop_kind),
        .cmd_dropped(cmd_dropped)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle
    always @(negedge clock) begin
        if (send_data_tx === 1'b1) tx_count++;
        if (sensor_start === 1'b1) start_count++;
    end

    // Hard stop in case a scenario wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] a);
        new_data     = 1'b1;
        next_command = c;
        next_address = a;
        tick();
        new_data = 1'b0;
    endtask

    task automatic wait_start(input int budget, output bit ok, output logic [7:0] addr);
        int n = 0;
        ok   = 1'b0;
        addr = '0;
        while (!ok && n < budget) begin
            if (sensor_start === 1'b1) begin
                ok   = 1'b1;
                addr = sensor_addr;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic finish_read(input logic [DATA_W-1:0] d, input int delay, input bit err);
        repeat (delay) tick();
        sensor_done  = 1'b1;
        sensor_error = err;
        data_sensor  = d;
        tick();
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
        data_sensor  = '0;
    endtask

    task automatic get_resp(input int budget, output bit ok, output logic [2:0] st,
                            output logic [7:0] c, output logic [7:0] a,
                            output logic [DATA_W-1:0] d);
        int n = 0;
        ok = 1'b0;
        st = '0;
        c  = '0;
        a  = '0;
        d  = '0;
        while (!ok && n < budget) begin
            if (send_data_tx === 1'b1) begin
                ok = 1'b1;
                st = resp_status;
                c  = resp_command;
                a  = resp_address;
                d  = resp_data;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        new_data     = 1'b1;
        next_command = 8'd2;
        next_address = 8'd3;
        repeat (3) tick();
        total++; if ({sensor_start, sensor_addr, send_data_tx, resp_status, resp_command, resp_address, resp_data, rest_uart_rx, cmd_dropped} !== '0) begin bad++; $display("[TB] FAIL reset_outputs: got %h, want 0", {sensor_start, sensor_addr, send_data_tx, resp_status, resp_command, resp_address, resp_data, rest_uart_rx, cmd_dropped}); end
        total++; if ({loop_active, loop_kind} !== '0) begin bad++; $display("[TB] FAIL reset_loops: got %h, want 0", {loop_active, loop_kind}); end
        new_data = 1'b0;
        reset    = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_read();
        bit ok; logic [2:0] st; logic [7:0] c, a; logic [DATA_W-1:0] d; int t0;
        t0 = tx_count;
        send_cmd(8'd2, 8'd3);
        total++; if (rest_uart_rx !== 1'b1) begin bad++; $display("[TB] FAIL capture_ack: got %b, want 1", rest_uart_rx); end
        tick();
        total++; if (sensor_start !== 1'b0) begin bad++; $display("[TB] FAIL start_early: got %b, want 0", sensor_start); end
        tick();
        total++; if (sensor_start !== 1'b1) begin bad++; $display("[TB] FAIL start_latency: got %b, want 1", sensor_start); end
        total++; if (sensor_addr !== 8'd3) begin bad++; $display("[TB] FAIL start_addr: got %0d, want 3", sensor_addr); end
        tick();
        total++; if (sensor_start !== 1'b0) begin bad++; $display("[TB] FAIL start_one_cycle: got %b, want 0", sensor_start); end
        finish_read(40'h12_3456_789A, 9, 1'b0);
        get_resp(10, ok, st, c, a, d);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL read_resp_seen: got %b, want 1", ok); end
        total++; if ({st, c, a} !== {3'd0, 8'd2, 8'd3}) begin bad++; $display("[TB] FAIL read_resp_hdr: got %h, want %h", {st, c, a}, {3'd0, 8'd2, 8'd3}); end
        total++; if (d !== 40'h12_3456_789A) begin bad++; $display("[TB] FAIL read_resp_data: got %h, want 123456789a", d); end
        tick();
        total++; if (send_data_tx !== 1'b0) begin bad++; $display("[TB] FAIL tx_one_cycle: got %b, want 0", send_data_tx); end
        total++; if (resp_data !== 40'h12_3456_789A) begin bad++; $display("[TB] FAIL resp_held: got %h, want 123456789a", resp_data); end
        total++; if (tx_count - t0 !== 1) begin bad++; $display("[TB] FAIL tx_pulses: got %0d, want 1", tx_count - t0); end
    endtask

    task automatic test_decode_errors();
        bit ok; logic [2:0] st; logic [7:0] c, a; logic [DATA_W-1:0] d; int s0;
        s0 = start_count;
        send_cmd(8'd9, 8'd40);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd1, 8'd9, 8'd40}) begin bad++; $display("[TB] FAIL bad_cmd_resp: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd1, 8'd9, 8'd40}); end
        total++; if (d !== '0) begin bad++; $display("[TB] FAIL bad_cmd_data: got %h, want 0", d); end
        tick();
        send_cmd(8'd1, 8'd40);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd2, 8'd1, 8'd40}) begin bad++; $display("[TB] FAIL bad_addr_resp: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd2, 8'd1, 8'd40}); end
        tick();
        total++; if (start_count !== s0) begin bad++; $display("[TB] FAIL no_sensor_start: got %0d, want %0d", start_count, s0); end
    endtask

    task automatic test_timeout_and_error();
        bit ok; logic [2:0] st; logic [7:0] c, a; logic [DATA_W-1:0] d; int n;
        send_cmd(8'd3, 8'd2);
        wait_start(10, ok, a);
        total++; if ({ok, a} !== {1'b1, 8'd2}) begin bad++; $display("[TB] FAIL timeout_start: got %h, want %h", {ok, a}, {1'b1, 8'd2}); end
        n = 0;
        while (send_data_tx !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        total++; if (!(n >= TIMEOUT_CYCLES && n <= TIMEOUT_CYCLES + 4)) begin bad++; $display("[TB] FAIL timeout_latency: got %0d cycles, want %0d..%0d", n, TIMEOUT_CYCLES, TIMEOUT_CYCLES + 4); end
        total++; if ({resp_status, resp_command, resp_address, resp_data} !== {3'd4, 8'd3, 8'd2, 40'd0}) begin bad++; $display("[TB] FAIL timeout_resp: got %h, want %h", {resp_status, resp_command, resp_address, resp_data}, {3'd4, 8'd3, 8'd2, 40'd0}); end
        tick();
        send_cmd(8'd1, 8'd5);
        wait_start(10, ok, a);
        finish_read(40'hAB, 2, 1'b1);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a, d} !== {1'b1, 3'd3, 8'd1, 8'd5, 40'd0}) begin bad++; $display("[TB] FAIL error_beats_done: got %h, want %h", {ok, st, c, a, d}, {1'b1, 3'd3, 8'd1, 8'd5, 40'd0}); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok; logic [2:0] st; logic [7:0] c, a; logic [DATA_W-1:0] d; int s0; int early;
        send_cmd(8'd1, 8'd4);
        wait_start(10, ok, a);
        send_cmd(8'd2, 8'd6);
        total++; if ({rest_uart_rx, cmd_dropped} !== 2'b10) begin bad++; $display("[TB] FAIL first_pending: got %b, want 10", {rest_uart_rx, cmd_dropped}); end
        send_cmd(8'd3, 8'd8);
        total++; if ({rest_uart_rx, cmd_dropped} !== 2'b01) begin bad++; $display("[TB] FAIL second_dropped: got %b, want 01", {rest_uart_rx, cmd_dropped}); end
        tx_busy = 1'b1;
        finish_read(40'h55, 1, 1'b0);
        early = 0;
        repeat (5) begin
            tick();
            if (send_data_tx === 1'b1) early++;
        end
        total++; if (early !== 0) begin bad++; $display("[TB] FAIL tx_while_busy: got %0d strobes, want 0", early); end
        tx_busy = 1'b0;
        get_resp(5, ok, st, c, a, d);
        total++; if ({ok, st, c, a, d} !== {1'b1, 3'd0, 8'd1, 8'd4, 40'h55}) begin bad++; $display("[TB] FAIL busy_release_resp: got %h, want %h", {ok, st, c, a, d}, {1'b1, 3'd0, 8'd1, 8'd4, 40'h55}); end
        wait_start(10, ok, a);
        total++; if ({ok, a} !== {1'b1, 8'd6}) begin bad++; $display("[TB] FAIL pending_served: got %h, want %h", {ok, a}, {1'b1, 8'd6}); end
        finish_read(40'h66, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a, d} !== {1'b1, 3'd0, 8'd2, 8'd6, 40'h66}) begin bad++; $display("[TB] FAIL pending_resp: got %h, want %h", {ok, st, c, a, d}, {1'b1, 3'd0, 8'd2, 8'd6, 40'h66}); end
        s0 = start_count;
        repeat (12) tick();
        total++; if (start_count !== s0) begin bad++; $display("[TB] FAIL dropped_not_served: got %0d, want %0d", start_count, s0); end
    endtask

    task automatic test_loops();
        bit ok; logic [2:0] st; logic [7:0] c, a; logic [DATA_W-1:0] d; int s0;
        logic [7:0] exp_addr [4];
        logic [7:0] exp_cmd [4];
        exp_addr = '{8'd1, 8'd7, 8'd1, 8'd7};
        exp_cmd  = '{8'd4, 8'd5, 8'd4, 8'd5};
        send_cmd(8'd4, 8'd1);
        wait_start(10, ok, a);
        send_cmd(8'd5, 8'd7);
        finish_read(40'h1001, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd0, 8'd4, 8'd1}) begin bad++; $display("[TB] FAIL loop_start_temp: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd0, 8'd4, 8'd1}); end
        wait_start(10, ok, a);
        finish_read(40'h7007, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd0, 8'd5, 8'd7}) begin bad++; $display("[TB] FAIL loop_start_hum: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd0, 8'd5, 8'd7}); end
        total++; if ({loop_active, loop_kind} !== {32'h0000_0082, 32'h0000_0080}) begin bad++; $display("[TB] FAIL loop_bitmaps: got %h, want 0000008200000080", {loop_active, loop_kind}); end
        for (int i = 0; i < 4; i++) begin
            wait_start(10, ok, a);
            total++; if ({ok, a} !== {1'b1, exp_addr[i]}) begin bad++; $display("[TB] FAIL rr_addr_%0d: got %h, want %h", i, {ok, a}, {1'b1, exp_addr[i]}); end
            finish_read(DATA_W'(i + 16), 2, 1'b0);
            get_resp(10, ok, st, c, a, d);
            total++; if ({ok, c, a, d} !== {1'b1, exp_cmd[i], exp_addr[i], DATA_W'(i + 16)}) begin bad++; $display("[TB] FAIL rr_resp_%0d: got %h, want %h", i, {ok, c, a, d}, {1'b1, exp_cmd[i], exp_addr[i], DATA_W'(i + 16)}); end
        end
        wait_start(10, ok, a);
        send_cmd(8'd6, 8'd1);
        finish_read(40'h2002, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a, d} !== {1'b1, 3'd0, 8'd4, 8'd1, 40'h2002}) begin bad++; $display("[TB] FAIL midread_complete: got %h, want %h", {ok, st, c, a, d}, {1'b1, 3'd0, 8'd4, 8'd1, 40'h2002}); end
        s0 = start_count;
        tick();
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd5, 8'd6, 8'd1}) begin bad++; $display("[TB] FAIL stop_resp: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd5, 8'd6, 8'd1}); end
        total++; if (start_count !== s0) begin bad++; $display("[TB] FAIL stop_no_read: got %0d, want %0d", start_count, s0); end
        total++; if (loop_active !== 32'h0000_0080) begin bad++; $display("[TB] FAIL stop_bitmap: got %h, want 00000080", loop_active); end
        wait_start(10, ok, a);
        total++; if ({ok, a} !== {1'b1, 8'd7}) begin bad++; $display("[TB] FAIL only7_a: got %h, want %h", {ok, a}, {1'b1, 8'd7}); end
        finish_read(40'h3003, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        tick();
        wait_start(10, ok, a);
        total++; if ({ok, a} !== {1'b1, 8'd7}) begin bad++; $display("[TB] FAIL only7_b: got %h, want %h", {ok, a}, {1'b1, 8'd7}); end
        send_cmd(8'd7, 8'd1);
        finish_read(40'h4004, 2, 1'b0);
        get_resp(10, ok, st, c, a, d);
        tick();
        get_resp(10, ok, st, c, a, d);
        total++; if ({ok, st, c, a} !== {1'b1, 3'd6, 8'd7, 8'd1}) begin bad++; $display("[TB] FAIL stop_mismatch: got %h, want %h", {ok, st, c, a}, {1'b1, 3'd6, 8'd7, 8'd1}); end
        total++; if ({loop_active, loop_kind} !== {32'h0000_0080, 32'h0000_0080}) begin bad++; $display("[TB] FAIL stop_mismatch_bitmap: got %h, want 0000008000000080", {loop_active, loop_kind}); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok; logic [7:0] a; int t0; int s0;
        wait_start(10, ok, a);
        total++; if (ok !== 1'b1) begin bad++; $display("[TB] FAIL loop_before_reset: got %b, want 1", ok); end
        tick();
        t0           = tx_count;
        reset        = 1'b1;
        new_data     = 1'b1;
        next_command = 8'd1;
        next_address = 8'd2;
        tick();
        new_data = 1'b0;
        total++; if ({sensor_start, sensor_addr, send_data_tx, resp_status, resp_command, resp_address, resp_data, rest_uart_rx, cmd_dropped} !== '0) begin bad++; $display("[TB] FAIL midreset_outputs: got %h, want 0", {sensor_start, sensor_addr, send_data_tx, resp_status, resp_command, resp_address, resp_data, rest_uart_rx, cmd_dropped}); end
        total++; if ({loop_active, loop_kind} !== '0) begin bad++; $display("[TB] FAIL midreset_loops: got %h, want 0", {loop_active, loop_kind}); end
        tick();
        reset = 1'b0;
        s0    = start_count;
        repeat (20) tick();
        total++; if (tx_count !== t0) begin bad++; $display("[TB] FAIL midreset_no_resp: got %0d, want %0d", tx_count, t0); end
        total++; if (start_count !== s0) begin bad++; $display("[TB] FAIL midreset_idle: got %0d, want %0d", start_count, s0); end
    endtask

    // Scenario sequence
    initial begin
        reset        = 1'b1;
        new_data     = 1'b0;
        next_command = '0;
        next_address = '0;
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
        data_sensor  = '0;
        tx_busy      = 1'b0;
        test_reset();
        test_single_read();
        test_decode_errors();
        test_timeout_and_error();
        test_back_to_back();
        test_loops();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
